// File: rtl/clock_pkg.sv
// Shared types and helpers for the HH:MM:SS run/set controller.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_H,
        ST_SET_M,
        ST_SET_S,
        ST_COMMIT
    } state_e;

    localparam logic [1:0] FS_NONE = 2'd0;
    localparam logic [1:0] FS_HOUR = 2'd1;
    localparam logic [1:0] FS_MIN  = 2'd2;
    localparam logic [1:0] FS_SEC  = 2'd3;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    // Add 0..2 to a field and wrap at vmax; one subtraction suffices for amt <= vmax+1.
    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [1:0] amt,
                                            input logic [5:0] vmax);
        logic [6:0] s;
        s = {1'b0, v} + {5'b0, amt};
        if (s > {1'b0, vmax}) s = s - ({1'b0, vmax} + 7'd1);
        return s[5:0];
    endfunction

    // Keypad shift-in: keep the old units digit as tens if the result is in range,
    // otherwise restart the field with the new digit alone.
    function automatic logic [5:0] digit_shift(input logic [5:0] f, input logic [3:0] d,
                                               input logic [5:0] fmax);
        logic [6:0] lo;
        logic [6:0] cand;
        lo   = 7'(f % 6'd10);
        cand = lo * 7'd10 + {3'b0, d};
        return (cand <= {1'b0, fmax}) ? cand[5:0] : {2'b0, d};
    endfunction

    function automatic logic [1:0] field_of(input state_e s);
        case (s)
            ST_SET_H: return FS_HOUR;
            ST_SET_M: return FS_MIN;
            ST_SET_S: return FS_SEC;
            default:  return FS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-DIV counter producing a one-cycle strobe on its last count.
// A synchronous clear restarts the count and suppresses the strobe in that cycle.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic strobe_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, wrap on the last count, else increment.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i)              cnt_d = '0;
        else if (cnt_q == LAST) cnt_d = '0;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign strobe_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/clock_time_setter.sv
// Run/set controller for the HH:MM:SS clock: live time counting, shadow-copy
// field editing from keypad digits, abort/commit, and fast h/min bumps in RUN.
// Optional hourly chime is built only when CLOCK_CHIME_EN is defined.
module clock_time_setter
    import clock_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int HOUR_MAX  = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change,
    input  logic       next,
    input  logic       h,
    input  logic       min,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] field_sel,
    output logic       blink,
    output logic       chime
);

    localparam logic [5:0] HMAX = 6'(HOUR_MAX);

    state_e     state_q, state_d;
    logic [5:0] hr_q, hr_d, mn_q, mn_d, sc_q, sc_d;
    logic [5:0] sh_hr_q, sh_hr_d, sh_mn_q, sh_mn_d, sh_sc_q, sh_sc_d;
    logic       blink_st_q, blink_st_d;
    logic [5:0] hour_q, minute_q, second_q;
    logic [1:0] field_sel_q;
    logic       blink_q;

    logic tick, blink_tick;
    logic in_run, in_set, commit, set_entry;
    logic roll_s, roll_m, key_ok;

    assign in_run    = (state_q == ST_RUN);
    assign in_set    = (state_q == ST_SET_H) || (state_q == ST_SET_M) || (state_q == ST_SET_S);
    assign commit    = (state_q == ST_COMMIT);
    assign set_entry = in_run && change;
    assign key_ok    = key_valid && (key_digit <= 4'd9);
    assign roll_s    = tick && (sc_q == SEC_MAX);
    assign roll_m    = roll_s && (mn_q == MIN_MAX);

    // Second tick restarts on commit so the committed time gets a full second.
    tick_prescaler #(.DIV(TICK_DIV)) u_sec_div (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (commit),
        .strobe_o (tick)
    );

    // Blink phase restarts on every set entry.
    tick_prescaler #(.DIV(BLINK_DIV)) u_blink_div (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (set_entry),
        .strobe_o (blink_tick)
    );

    // FSM next state; change always wins over next.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (change) state_d = ST_SET_H;
            ST_SET_H:  if (change) state_d = ST_RUN; else if (next) state_d = ST_SET_M;
            ST_SET_M:  if (change) state_d = ST_RUN; else if (next) state_d = ST_SET_S;
            ST_SET_S:  if (change) state_d = ST_RUN; else if (next) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Live time: commit load, else tick carries plus RUN-only per-field bumps.
    always_comb begin
        hr_d = hr_q;
        mn_d = mn_q;
        sc_d = sc_q;
        if (commit) begin
            hr_d = sh_hr_q;
            mn_d = sh_mn_q;
            sc_d = sh_sc_q;
        end else begin
            if (tick) sc_d = roll_s ? 6'd0 : sc_q + 6'd1;
            mn_d = inc_wrap(mn_q, {1'b0, roll_s} + {1'b0, in_run && min}, MIN_MAX);
            hr_d = inc_wrap(hr_q, {1'b0, roll_m} + {1'b0, in_run && h}, HMAX);
        end
    end

    // Shadow time: snapshot on set entry, digit shift-in on the edited field.
    always_comb begin
        sh_hr_d = sh_hr_q;
        sh_mn_d = sh_mn_q;
        sh_sc_d = sh_sc_q;
        if (set_entry) begin
            sh_hr_d = hr_q;
            sh_mn_d = mn_q;
            sh_sc_d = sc_q;
        end else if (in_set && key_ok) begin
            case (state_q)
                ST_SET_H: sh_hr_d = digit_shift(sh_hr_q, key_digit, HMAX);
                ST_SET_M: sh_mn_d = digit_shift(sh_mn_q, key_digit, MIN_MAX);
                ST_SET_S: sh_sc_d = digit_shift(sh_sc_q, key_digit, SEC_MAX);
                default:  ;
            endcase
        end
    end

    // Blink phase: starts high on entry, toggles while staying in a SET state, low otherwise.
    always_comb begin
        blink_st_d = 1'b0;
        if (set_entry)
            blink_st_d = 1'b1;
        else if (in_set && (state_d != ST_RUN) && (state_d != ST_COMMIT))
            blink_st_d = blink_st_q ^ blink_tick;
    end

    // Core state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            hr_q       <= '0;
            mn_q       <= '0;
            sc_q       <= '0;
            sh_hr_q    <= '0;
            sh_mn_q    <= '0;
            sh_sc_q    <= '0;
            blink_st_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hr_q       <= hr_d;
            mn_q       <= mn_d;
            sc_q       <= sc_d;
            sh_hr_q    <= sh_hr_d;
            sh_mn_q    <= sh_mn_d;
            sh_sc_q    <= sh_sc_d;
            blink_st_q <= blink_st_d;
        end
    end

    // Registered display view: live time in RUN, shadow while editing or committing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hour_q      <= '0;
            minute_q    <= '0;
            second_q    <= '0;
            field_sel_q <= FS_NONE;
            blink_q     <= 1'b0;
        end else begin
            if (in_run) begin
                hour_q   <= hr_q;
                minute_q <= mn_q;
                second_q <= sc_q;
            end else begin
                hour_q   <= sh_hr_q;
                minute_q <= sh_mn_q;
                second_q <= sh_sc_q;
            end
            field_sel_q <= field_of(state_q);
            blink_q     <= blink_st_q;
        end
    end

`ifdef CLOCK_CHIME_EN
    logic chime_st_q, chime_st_d, chime_q;

    // Chime holds for one second after the live rollover to mm:ss = 00:00.
    always_comb begin
        chime_st_d = chime_st_q;
        if (tick) chime_st_d = roll_m;
    end

    // Chime state plus output stage aligned with the time display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chime_st_q <= 1'b0;
            chime_q    <= 1'b0;
        end else begin
            chime_st_q <= chime_st_d;
            chime_q    <= chime_st_q;
        end
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

    assign hour      = hour_q;
    assign minute    = minute_q;
    assign second    = second_q;
    assign field_sel = field_sel_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: directed vector table, mid-set reset sequence,
// and randomized pulses checked every cycle against a reference model.
module tb_clock_time_setter;

    localparam int TD = 4;
    localparam int BD = 2;
    localparam int HM = 23;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       change = 1'b0, nxt = 1'b0, hp = 1'b0, mp = 1'b0, kv = 1'b0;
    logic [3:0] kd = 4'd0;
    logic [5:0] hour, minute, second;
    logic [1:0] field_sel;
    logic       blink, chime;

    int n_cmp  = 0;
    int n_fail = 0;

    clock_time_setter #(.TICK_DIV(TD), .BLINK_DIV(BD), .HOUR_MAX(HM)) dut (
        .clk       (clk),
        .rst       (rst),
        .change    (change),
        .next      (nxt),
        .h         (hp),
        .min       (mp),
        .key_valid (kv),
        .key_digit (kd),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .field_sel (field_sel),
        .blink     (blink),
        .chime     (chime)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 run, 1 set hour, 2 set minute, 3 set second, 4 commit
    int m_mode, m_h, m_m, m_s, m_sh, m_sm, m_ss, m_pre, m_bpre;
    bit m_blk, m_chm;
    int e_h, e_m, e_s, e_f;
    bit e_blk, e_chm;

    function automatic int shift_in(input int f, input int d, input int mx);
        int c;
        c = (f % 10) * 10 + d;
        return (c <= mx) ? c : d;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_sh = 0; m_sm = 0; m_ss = 0;
        m_pre = 0; m_bpre = 0; m_blk = 0; m_chm = 0;
        e_h = 0; e_m = 0; e_s = 0; e_f = 0; e_blk = 0; e_chm = 0;
    endtask

    // One clock edge with the inputs currently driven.
    task automatic model_step();
        bit run, cmt, inset, entry, tk, btk, rs, rm;
        int nmode, oh, om, os;
        run   = (m_mode == 0);
        cmt   = (m_mode == 4);
        inset = (m_mode >= 1 && m_mode <= 3);
        // outputs show the view held before this edge
        e_h = run ? m_h : m_sh;
        e_m = run ? m_m : m_sm;
        e_s = run ? m_s : m_ss;
        e_f = inset ? m_mode : 0;
        e_blk = m_blk;
`ifdef CLOCK_CHIME_EN
        e_chm = m_chm;
`else
        e_chm = 0;
`endif
        tk    = !cmt && (m_pre == TD - 1);
        m_pre = cmt ? 0 : (m_pre + 1) % TD;
        entry = run && change;
        btk   = !entry && (m_bpre == BD - 1);
        m_bpre = entry ? 0 : (m_bpre + 1) % BD;

        nmode = m_mode;
        if (run) nmode = change ? 1 : 0;
        else if (cmt) nmode = 0;
        else if (change) nmode = 0;
        else if (nxt) nmode = m_mode + 1;

        oh = m_h; om = m_m; os = m_s;
        if (cmt) begin
            m_h = m_sh; m_m = m_sm; m_s = m_ss;
        end else begin
            rs  = tk && (m_s == 59);
            rm  = rs && (m_m == 59);
            m_s = tk ? (m_s + 1) % 60 : m_s;
            m_m = (m_m + int'(rs) + int'(run && mp)) % 60;
            m_h = (m_h + int'(rm) + int'(run && hp)) % (HM + 1);
            if (tk) m_chm = rm;
        end

        if (entry) begin
            m_sh = oh; m_sm = om; m_ss = os;
        end else if (inset && kv && kd <= 9) begin
            if (m_mode == 1) m_sh = shift_in(m_sh, int'(kd), HM);
            if (m_mode == 2) m_sm = shift_in(m_sm, int'(kd), 59);
            if (m_mode == 3) m_ss = shift_in(m_ss, int'(kd), 59);
        end

        if (entry) m_blk = 1;
        else if (inset && nmode >= 1 && nmode <= 3) m_blk = m_blk ^ btk;
        else m_blk = 0;

        m_mode = nmode;
    endtask

    task automatic model_check();
        cmp("mdl_hour", int'(hour), e_h);
        cmp("mdl_minute", int'(minute), e_m);
        cmp("mdl_second", int'(second), e_s);
        cmp("mdl_field_sel", int'(field_sel), e_f);
        cmp("mdl_blink", int'(blink), int'(e_blk));
        cmp("mdl_chime", int'(chime), int'(e_chm));
    endtask

    task automatic run_cyc();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic clear_in();
        change = 0; nxt = 0; hp = 0; mp = 0; kv = 0; kd = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       c, n, hh, mm, k;
        int       d;
        int       cy;
        bit [3:0] msk;   // hour, minute, second, field_sel
        int       eh, em, es, ef;
    } vec_t;

    localparam bit [3:0] ALL = 4'b1111;
    localparam bit [3:0] HF  = 4'b1001;
    localparam bit [3:0] MF  = 4'b0101;
    localparam bit [3:0] SF  = 4'b0011;
    localparam bit [3:0] FO  = 4'b0001;

    vec_t tbl[$];

    function automatic vec_t mk(bit c, bit n, bit hh, bit mm, bit k, int d, int cy,
                                bit [3:0] msk, int eh, int em, int es, int ef);
        vec_t v;
        v.c = c; v.n = n; v.hh = hh; v.mm = mm; v.k = k; v.d = d; v.cy = cy;
        v.msk = msk; v.eh = eh; v.em = em; v.es = es; v.ef = ef;
        return v;
    endfunction

    task automatic apply_vec(input int idx, input vec_t v);
        change = v.c; nxt = v.n; hp = v.hh; mp = v.mm; kv = v.k; kd = 4'(v.d);
        run_cyc();
        clear_in();
        for (int i = 1; i < v.cy; i++) run_cyc();
        if (v.msk[3]) cmp($sformatf("vec%0d_hour", idx), int'(hour), v.eh);
        if (v.msk[2]) cmp($sformatf("vec%0d_minute", idx), int'(minute), v.em);
        if (v.msk[1]) cmp($sformatf("vec%0d_second", idx), int'(second), v.es);
        if (v.msk[0]) cmp($sformatf("vec%0d_field_sel", idx), int'(field_sel), v.ef);
    endtask

    initial begin
        //            c n h m k  d  cy  msk  hh mm ss f
        tbl.push_back(mk(0,0,0,0,0, 0,241, ALL,  0, 1, 0,0)); // 60 s of ticks
        // preload 23:59:59 and roll over
        tbl.push_back(mk(1,0,0,0,0, 0,  2, ALL,  0, 1, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 2,  2, ALL,  2, 1, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 3,  2, ALL, 23, 1, 0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, ALL, 23, 1, 0,2));
        tbl.push_back(mk(0,0,0,0,1, 5,  2, ALL, 23,15, 0,2));
        tbl.push_back(mk(0,0,0,0,1, 9,  2, ALL, 23,59, 0,2));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, ALL, 23,59, 0,3));
        tbl.push_back(mk(0,0,0,0,1, 5,  2, ALL, 23,59, 5,3));
        tbl.push_back(mk(0,0,0,0,1, 9,  2, ALL, 23,59,59,3));
        tbl.push_back(mk(0,1,0,0,0, 0,  3, ALL, 23,59,59,0));
        tbl.push_back(mk(0,0,0,0,0, 0,  4, ALL,  0, 0, 0,0));
        // 12:34:56 entry; one full second after commit shows :57
        tbl.push_back(mk(1,0,0,0,0, 0,  2, ALL,  0, 0, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,  2, ALL,  1, 0, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 2,  2, ALL, 12, 0, 0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, ALL, 12, 0, 0,2));
        tbl.push_back(mk(0,0,0,0,1, 3,  2, ALL, 12, 3, 0,2));
        tbl.push_back(mk(0,0,0,0,1, 4,  2, ALL, 12,34, 0,2));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, ALL, 12,34, 0,3));
        tbl.push_back(mk(0,0,0,0,1, 5,  2, ALL, 12,34, 5,3));
        tbl.push_back(mk(0,0,0,0,1, 6,  2, ALL, 12,34,56,3));
        tbl.push_back(mk(0,1,0,0,0, 0,  3, ALL, 12,34,56,0));
        tbl.push_back(mk(0,0,0,0,0, 0,  4, ALL, 12,34,57,0));
        // out-of-range candidates, invalid digit, aborts
        tbl.push_back(mk(1,0,0,0,0, 0,  2, FO,   0, 0, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 2,  2, HF,  22, 0, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 5,  2, HF,   5, 0, 0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, FO,   0, 0, 0,2));
        tbl.push_back(mk(0,0,0,0,1, 6,  2, MF,   0,46, 0,2));
        tbl.push_back(mk(0,0,0,0,1, 7,  2, MF,   0, 7, 0,2));
        tbl.push_back(mk(0,0,0,0,1,12,  2, MF,   0, 7, 0,2));
        tbl.push_back(mk(1,0,0,0,0, 0,  2, HF,  12, 0, 0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,  2, FO,   0, 0, 0,1));
        tbl.push_back(mk(1,1,0,0,0, 0,  2, HF,  12, 0, 0,0));
        // 10:59:30 then min pulse wraps the minute without carry
        tbl.push_back(mk(1,0,0,0,0, 0,  2, FO,   0, 0, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,  2, HF,  21, 0, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 0,  2, HF,  10, 0, 0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, FO,   0, 0, 0,2));
        tbl.push_back(mk(0,0,0,0,1, 5,  2, FO,   0, 0, 0,2));
        tbl.push_back(mk(0,0,0,0,1, 9,  2, MF,   0,59, 0,2));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, FO,   0, 0, 0,3));
        tbl.push_back(mk(0,0,0,0,1, 3,  2, FO,   0, 0, 0,3));
        tbl.push_back(mk(0,0,0,0,1, 0,  2, SF,   0, 0,30,3));
        tbl.push_back(mk(0,1,0,0,0, 0,  3, ALL, 10,59,30,0));
        tbl.push_back(mk(0,0,0,1,0, 0,  2, ALL, 10, 0,30,0));
        // hour 23 then h pulse wraps to 0
        tbl.push_back(mk(1,0,0,0,0, 0,  2, FO,   0, 0, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 2,  2, HF,   2, 0, 0,1));
        tbl.push_back(mk(0,0,0,0,1, 3,  2, HF,  23, 0, 0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, FO,   0, 0, 0,2));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, FO,   0, 0, 0,3));
        tbl.push_back(mk(0,1,0,0,0, 0,  3, HF,  23, 0, 0,0));
        tbl.push_back(mk(0,0,1,0,0, 0,  2, HF,   0, 0, 0,0));
        // h pulse in SET_S is ignored
        tbl.push_back(mk(1,0,0,0,0, 0,  2, HF,   0, 0, 0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, FO,   0, 0, 0,2));
        tbl.push_back(mk(0,1,0,0,0, 0,  2, FO,   0, 0, 0,3));
        tbl.push_back(mk(0,0,1,0,0, 0,  2, HF,   0, 0, 0,3));
        tbl.push_back(mk(1,0,0,0,0, 0,  2, HF,   0, 0, 0,0));

        // reset state
        model_reset();
        #2 rst = 1'b0;
        #10;
        cmp("rst_hour", int'(hour), 0);
        cmp("rst_minute", int'(minute), 0);
        cmp("rst_second", int'(second), 0);
        cmp("rst_field_sel", int'(field_sel), 0);
        cmp("rst_blink", int'(blink), 0);
        cmp("rst_chime", int'(chime), 0);
        @(negedge clk) rst = 1'b1;

        foreach (tbl[i]) apply_vec(i, tbl[i]);

        // reset asserted in the middle of a set: no commit, straight to zero
        change = 1; run_cyc(); clear_in(); run_cyc();
        kv = 1; kd = 4'd7; run_cyc(); clear_in(); run_cyc();
        cmp("midset_fsel", int'(field_sel), 1);
        #3 rst = 1'b0;
        model_reset();
        #1;
        cmp("midrst_hour", int'(hour), 0);
        cmp("midrst_minute", int'(minute), 0);
        cmp("midrst_second", int'(second), 0);
        cmp("midrst_field_sel", int'(field_sel), 0);
        cmp("midrst_blink", int'(blink), 0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) run_cyc();
        cmp("postrst_hour", int'(hour), 0);
        cmp("postrst_field_sel", int'(field_sel), 0);

        // randomized pulses against the model
        for (int i = 0; i < 3000; i++) begin
            change = ($urandom_range(0, 39) == 0);
            nxt    = ($urandom_range(0, 7) == 0);
            hp     = ($urandom_range(0, 19) == 0);
            mp     = ($urandom_range(0, 19) == 0);
            kv     = ($urandom_range(0, 3) == 0);
            kd     = 4'($urandom_range(0, 15));
            run_cyc();
        end
        clear_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
